h264_chroma_sched: RTL

// - Frame-level sequencer for the chroma 8x8 intra/DC-prediction stage (h264intra8x8cc).
// - Pulls chroma words from the macroblock source: 16 Cb words, then 16 Cr words, per macroblock.
// - Strobes those words into the stage and issues NEWSLICE/NEWLINE at frame and MB-row boundaries.
// - Counts completed macroblocks (XXINC) and drives the top-row store address (TOPADDR).

---
 rtl/h264_chroma_sched_pkg.sv | 22 ++
 rtl/h264_chroma_sched.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/h264_chroma_sched_pkg.sv
// ---------------------------------------------------------------------------
// h264_chroma_pkg
// Shared types and constants for the chroma 8x8 intra/DC-prediction sequencer.
// Contents:
//   sched_state_t   - sequencer FSM states
//   WORDS_PER_MB    - chroma words per macroblock (16 Cb followed by 16 Cr)
//   WORDS_PER_COMP  - chroma words per colour component
// ---------------------------------------------------------------------------
package h264_chroma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SLICE = 3'd1,
        FEED  = 3'd2,
        LINE  = 3'd3,
        FIN   = 3'd4
    } sched_state_t;

    localparam int WORDS_PER_MB   = 32;
    localparam int WORDS_PER_COMP = 16;

endpackage

// File: rtl/h264_chroma_sched.sv
// ---------------------------------------------------------------------------
// h264_chroma_sched
// Frame-level sequencer for the chroma intra 8x8 prediction stage. It pulls
// 32 chroma words per macroblock (16 Cb, then 16 Cr) from the macroblock
// source, strobes them into the stage, marks frame and macroblock-row
// boundaries with NEWSLICE/NEWLINE, counts completed macroblocks from XXINC
// and forms the top-row store address.
// Ports:
//   CLK2, RESETN      clock (posedge) and asynchronous active-low reset
//   START             frame start pulse, only honoured while idle
//   BUSY, DONE        frame in progress / one-cycle end-of-frame pulse
//   SRC_VALID/DATA    chroma word offered by the source
//   SRC_READY         source pop (same as STROBEI)
//   READYI            stage can take a word
//   XXINC             stage finished one macroblock
//   XXO               stage {crcb, half} top-fetch select
//   STROBEI, DATAI    word write into the stage
//   NEWSLICE/NEWLINE  first-row-of-frame / start-of-row pulses
//   TOPADDR           {macroblocks done in row, XXO}
//   MBX, MBY          macroblocks fed in current row / current row
// ---------------------------------------------------------------------------
module h264_chroma_sched #(
    parameter int MB_WIDTH  = 20,
    parameter int MB_HEIGHT = 15,
    parameter int XW        = (MB_WIDTH  > 1) ? $clog2(MB_WIDTH)  : 1,
    parameter int YW        = (MB_HEIGHT > 1) ? $clog2(MB_HEIGHT) : 1
) (
    input  logic          CLK2,
    input  logic          RESETN,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    input  logic          SRC_VALID,
    input  logic [31:0]   SRC_DATA,
    output logic          SRC_READY,
    input  logic          READYI,
    input  logic          XXINC,
    input  logic [1:0]    XXO,
    output logic          STROBEI,
    output logic [31:0]   DATAI,
    output logic          NEWSLICE,
    output logic          NEWLINE,
    output logic [XW+1:0] TOPADDR,
    output logic [XW-1:0] MBX,
    output logic [YW-1:0] MBY
);

    import h264_chroma_pkg::*;

    // Column counters carry one extra bit so they can hold MB_WIDTH itself.
    localparam logic [XW:0] MBW      = (XW+1)'(MB_WIDTH);
    localparam logic [YW:0] LAST_ROW = (YW+1)'(MB_HEIGHT - 1);
    localparam logic [4:0]  LAST_WRD = 5'(WORDS_PER_MB - 1);

    sched_state_t  state_q, state_d;
    logic [4:0]    wcnt_q, wcnt_d;
    logic [XW:0]   mbxFed_q, mbxFed_d;
    logic [XW:0]   mbxDone_q, mbxDone_d;
    logic [YW-1:0] mby_q, mby_d;

    logic strobe;
    logic rowDone;
    logic moreRows;

    // The strobe has to be combinational: the stage drops READYI the cycle
    // after its 16th/32nd write, and a registered strobe would write one word
    // too many into a full buffer. The fed-count term stops row N+1 words
    // from entering before row N's NEWLINE.
    assign strobe   = (state_q == FEED) & SRC_VALID & READYI & (mbxFed_q < MBW);
    assign rowDone  = (mbxFed_q == MBW) && (mbxDone_q == MBW);
    assign moreRows = {1'b0, mby_q} < LAST_ROW;

    // State and counter registers.
    always_ff @(posedge CLK2 or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            mbxFed_q  <= '0;
            mbxDone_q <= '0;
            mby_q     <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mbxFed_q  <= mbxFed_d;
            mbxDone_q <= mbxDone_d;
            mby_q     <= mby_d;
        end
    end

    // Next-state and counter logic. A word-count wrap means a whole
    // macroblock has been handed over, so the stage may start loading the
    // next one while it processes this one. The row exit looks at the
    // registered counters, so a last strobe and an XXINC landing together
    // both count and the exit is taken the cycle after.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mbxFed_d  = mbxFed_q;
        mbxDone_d = mbxDone_q;
        mby_d     = mby_q;

        if (strobe) begin
            wcnt_d = wcnt_q + 5'd1;
            if (wcnt_q == LAST_WRD) begin
                mbxFed_d = mbxFed_q + 1'b1;
            end
        end

        if ((state_q == FEED) && XXINC && (mbxDone_q < MBW)) begin
            mbxDone_d = mbxDone_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = SLICE;
                end
            end
            SLICE: begin
                mby_d     = '0;
                wcnt_d    = '0;
                mbxFed_d  = '0;
                mbxDone_d = '0;
                state_d   = FEED;
            end
            FEED: begin
                if (rowDone) begin
                    state_d = moreRows ? LINE : FIN;
                end
            end
            LINE: begin
                mby_d     = mby_q + 1'b1;
                wcnt_d    = '0;
                mbxFed_d  = '0;
                mbxDone_d = '0;
                state_d   = FEED;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state so reset clears them at once.
    // NEWLINE only rises in SLICE/LINE, so it can never meet STROBEI.
    assign BUSY      = (state_q != IDLE);
    assign DONE      = (state_q == FIN);
    assign NEWSLICE  = (state_q == SLICE);
    assign NEWLINE   = (state_q == SLICE) || (state_q == LINE);
    assign STROBEI   = strobe;
    assign SRC_READY = strobe;
    assign DATAI     = SRC_DATA;
    assign TOPADDR   = {mbxDone_q[XW-1:0], XXO};
    assign MBX       = mbxFed_q[XW-1:0];
    assign MBY       = mby_q;

    // The stage may only report a finished macroblock while a row is feeding.
    assert property (@(posedge CLK2) disable iff (!RESETN) XXINC |-> (state_q == FEED));

endmodule
